// File: rtl/machine_csr_file_if.sv
// Zicsr access bus between pipeline stage 3 and the machine CSR file.
// The master issues address/op/data; the slave returns old value and fault.
interface machine_csr_file_if;
    logic [11:0] CSR_ADDR;
    logic [1:0]  CSR_OP;
    logic        CSR_WR_EN;
    logic [31:0] CSR_WDATA;
    logic [31:0] CSR_RDATA;
    logic        CSR_ILLEGAL;

    modport master (
        output CSR_ADDR, CSR_OP, CSR_WR_EN, CSR_WDATA,
        input  CSR_RDATA, CSR_ILLEGAL
    );

    modport slave (
        input  CSR_ADDR, CSR_OP, CSR_WR_EN, CSR_WDATA,
        output CSR_RDATA, CSR_ILLEGAL
    );
endinterface

// File: rtl/machine_csr_file.sv
// Machine-mode CSR storage and trap-state update for the Steel core.
// Serves Zicsr read/modify/write and tracks mstatus, mepc, mcause, counters.
module machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic              CLK,
    input  logic              RESET,
    machine_csr_file_if.slave csr,
    input  logic [31:0]       PC,
    input  logic              I_OR_E,
    input  logic              SET_EPC,
    input  logic              SET_CAUSE,
    input  logic [3:0]        CAUSE,
    input  logic              INSTRET_INC,
    input  logic              MIE_CLEAR,
    input  logic              MIE_SET,
    input  logic              E_IRQ,
    input  logic              T_IRQ,
    input  logic              S_IRQ,
    output logic              MIE,
    output logic              MEIE,
    output logic              MTIE,
    output logic              MSIE,
    output logic              MEIP,
    output logic              MTIP,
    output logic              MSIP,
    output logic [31:0]       TRAP_ADDR,
    output logic [31:0]       MEPC_OUT
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTR    = 12'hC02;
    localparam logic [11:0] A_INSTRH   = 12'hC82;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
    localparam logic [11:0] A_MARCH    = 12'hF12;
    localparam logic [11:0] A_MIMP     = 12'hF13;
    localparam logic [11:0] A_MHART    = 12'hF14;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic        msie_q, msie_d;
    logic [29:0] mtvec_base_q, mtvec_base_d;
    logic        mtvec_mode_q, mtvec_mode_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [29:0] mepc_q, mepc_d;
    logic        mcause_irq_q, mcause_irq_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
    logic        msip_sw_q, msip_sw_d;
    logic        meip_q, meip_d;
    logic        mtip_q, mtip_d;
    logic        msip_q, msip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        impl;
    logic [31:0] rdata_raw;
    logic        access;
    logic        illegal;
    logic        wr;
    logic [31:0] csr_new;
    logic        unused_pc;

    assign unused_pc = ^PC[1:0];

    always_comb begin
        impl      = 1'b1;
        rdata_raw = 32'h0;
        unique case (csr.CSR_ADDR)
            A_MSTATUS:  rdata_raw = {19'b0, 2'b11, 3'b0, mpie_q,
                                     3'b0, mie_q, 3'b0};
            A_MISA:     rdata_raw = MISA_VALUE;
            A_MIE:      rdata_raw = {20'b0, meie_q, 3'b0, mtie_q,
                                     3'b0, msie_q, 3'b0};
            A_MTVEC:    rdata_raw = {mtvec_base_q, 1'b0, mtvec_mode_q};
            A_MSCRATCH: rdata_raw = mscratch_q;
            A_MEPC:     rdata_raw = {mepc_q, 2'b00};
            A_MCAUSE:   rdata_raw = {mcause_irq_q, 27'b0, mcause_code_q};
            A_MTVAL:    rdata_raw = 32'h0;
            A_MIP:      rdata_raw = {20'b0, meip_q, 3'b0, mtip_q,
                                     3'b0, msip_q, 3'b0};
            A_MCYCLE, A_CYCLE:   rdata_raw = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: rdata_raw = mcycle_q[63:32];
            A_MINSTR, A_INSTR:   rdata_raw = minstret_q[31:0];
            A_MINSTRH, A_INSTRH: rdata_raw = minstret_q[63:32];
            A_MVENDOR, A_MARCH, A_MIMP, A_MHART: rdata_raw = 32'h0;
            default:    impl = 1'b0;
        endcase
    end

    // The 2'b11 address quadrant is read-only; writing it faults.
    assign access  = (csr.CSR_OP != 2'b00);
    assign illegal = access &&
                     (!impl || (csr.CSR_ADDR[11:10] == 2'b11 && csr.CSR_WR_EN));
    assign wr      = access && csr.CSR_WR_EN && !illegal;

    assign csr.CSR_ILLEGAL = illegal;
    assign csr.CSR_RDATA   = (access && impl) ? rdata_raw : 32'h0;

    always_comb begin
        unique case (csr.CSR_OP)
            2'b01:   csr_new = csr.CSR_WDATA;
            2'b10:   csr_new = rdata_raw | csr.CSR_WDATA;
            2'b11:   csr_new = rdata_raw & ~csr.CSR_WDATA;
            default: csr_new = rdata_raw;
        endcase
    end

    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        meie_d        = meie_q;
        mtie_d        = mtie_q;
        msie_d        = msie_q;
        mtvec_base_d  = mtvec_base_q;
        mtvec_mode_d  = mtvec_mode_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_irq_d  = mcause_irq_q;
        mcause_code_d = mcause_code_q;
        msip_sw_d     = msip_sw_q;
        mcycle_d      = mcycle_q + 64'd1;
        minstret_d    = minstret_q + {63'b0, INSTRET_INC};

        if (wr) begin
            case (csr.CSR_ADDR)
                A_MSTATUS: begin
                    mie_d  = csr_new[3];
                    mpie_d = csr_new[7];
                end
                A_MIE: begin
                    meie_d = csr_new[11];
                    mtie_d = csr_new[7];
                    msie_d = csr_new[3];
                end
                A_MTVEC: begin
                    mtvec_base_d = csr_new[31:2];
                    mtvec_mode_d = csr_new[0];
                end
                A_MSCRATCH: mscratch_d = csr_new;
                A_MEPC:     mepc_d     = csr_new[31:2];
                A_MCAUSE: begin
                    mcause_irq_d  = csr_new[31];
                    mcause_code_d = csr_new[3:0];
                end
                A_MIP:     msip_sw_d         = csr_new[3];
                A_MCYCLE:  mcycle_d[31:0]    = csr_new;
                A_MCYCLEH: mcycle_d[63:32]   = csr_new;
                A_MINSTR:  minstret_d[31:0]  = csr_new;
                A_MINSTRH: minstret_d[63:32] = csr_new;
                default: ;
            endcase
        end

        // Trap and mret strobes override a same-cycle CSR write.
        if (SET_EPC) begin
            mepc_d = PC[31:2];
        end
        if (SET_CAUSE) begin
            mcause_irq_d  = I_OR_E;
            mcause_code_d = CAUSE;
        end
        if (MIE_CLEAR) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (MIE_SET) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        meip_d = E_IRQ;
        mtip_d = T_IRQ;
        msip_d = msip_sw_d | S_IRQ;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            mtie_q        <= 1'b0;
            msie_q        <= 1'b0;
            mtvec_base_q  <= MTVEC_RESET[31:2];
            mtvec_mode_q  <= MTVEC_RESET[0];
            mscratch_q    <= 32'h0;
            mepc_q        <= 30'h0;
            mcause_irq_q  <= 1'b0;
            mcause_code_q <= 4'h0;
            msip_sw_q     <= 1'b0;
            meip_q        <= 1'b0;
            mtip_q        <= 1'b0;
            msip_q        <= 1'b0;
            mcycle_q      <= 64'h0;
            minstret_q    <= 64'h0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            meie_q        <= meie_d;
            mtie_q        <= mtie_d;
            msie_q        <= msie_d;
            mtvec_base_q  <= mtvec_base_d;
            mtvec_mode_q  <= mtvec_mode_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_irq_q  <= mcause_irq_d;
            mcause_code_q <= mcause_code_d;
            msip_sw_q     <= msip_sw_d;
            meip_q        <= meip_d;
            mtip_q        <= mtip_d;
            msip_q        <= msip_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
        end
    end

    assign MIE  = mie_q;
    assign MEIE = meie_q;
    assign MTIE = mtie_q;
    assign MSIE = msie_q;
    assign MEIP = meip_q;
    assign MTIP = mtip_q;
    assign MSIP = msip_q;

    // Vectored mode only offsets interrupts; exceptions use BASE.
    assign TRAP_ADDR = (mtvec_mode_q && mcause_irq_q)
                     ? {mtvec_base_q, 2'b00} + {26'b0, mcause_code_q, 2'b00}
                     : {mtvec_base_q, 2'b00};
    assign MEPC_OUT  = {mepc_q, 2'b00};

endmodule

// File: tb/tb_machine_csr_file.sv
// Self-checking bench for machine_csr_file: vector table, directed
// trap/counter/reset sequences and randomized accesses against a model.
module tb_machine_csr_file;

    localparam logic [31:0] TB_MTVEC = 32'h0000_2001;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic        I_OR_E, SET_EPC, SET_CAUSE, INSTRET_INC;
    logic [3:0]  CAUSE;
    logic        MIE_CLEAR, MIE_SET, E_IRQ, T_IRQ, S_IRQ;
    logic        MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP;
    logic [31:0] TRAP_ADDR, MEPC_OUT;

    machine_csr_file_if bus ();

    machine_csr_file #(.MTVEC_RESET(TB_MTVEC)) dut (
        .CLK(CLK), .RESET(RESET), .csr(bus),
        .PC(PC), .I_OR_E(I_OR_E), .SET_EPC(SET_EPC),
        .SET_CAUSE(SET_CAUSE), .CAUSE(CAUSE),
        .INSTRET_INC(INSTRET_INC), .MIE_CLEAR(MIE_CLEAR),
        .MIE_SET(MIE_SET), .E_IRQ(E_IRQ), .T_IRQ(T_IRQ),
        .S_IRQ(S_IRQ), .MIE(MIE), .MEIE(MEIE), .MTIE(MTIE),
        .MSIE(MSIE), .MEIP(MEIP), .MTIP(MTIP), .MSIP(MSIP),
        .TRAP_ADDR(TRAP_ADDR), .MEPC_OUT(MEPC_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: CSRs held as architectural words
    bit          m_mie, m_mpie, m_sw, m_meip, m_mtip, m_msip;
    logic [31:0] m_mier, m_mtvec, m_scratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ret;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    logic [11:0] alist [0:21] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
        12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
        12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11,
        12'hF14, 12'h7C0, 12'h345, 12'hF15
    };

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [11:0] a,
                                input logic we, input logic [31:0] wd,
                                input logic [31:0] rd, input logic ill);
        vec_t v;
        v.op = op; v.addr = a; v.we = we; v.wd = wd; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    task automatic mreset();
        m_mie = 0; m_mpie = 0; m_sw = 0; m_meip = 0; m_mtip = 0; m_msip = 0;
        m_mier = 0; m_mtvec = TB_MTVEC; m_scratch = 0; m_mepc = 0;
        m_mcause = 0; m_cyc = 0; m_ret = 0;
    endtask

    // {implemented, value}
    function automatic logic [32:0] mread(input logic [11:0] a);
        logic [31:0] v;
        bit ok;
        ok = 1;
        v  = 0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mier;
            12'h305: v = m_mtvec;
            12'h340: v = m_scratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = 0;
            12'h344: v = (32'(m_meip) << 11) | (32'(m_mtip) << 7) |
                         (32'(m_msip) << 3);
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ret[31:0];
            12'hB82, 12'hC82: v = m_ret[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 0;
            default: ok = 0;
        endcase
        return {ok, v};
    endfunction

    function automatic bit mill();
        logic [32:0] r;
        r = mread(bus.CSR_ADDR);
        return bus.CSR_OP != 0 &&
               (!r[32] || (bus.CSR_ADDR >= 12'hC00 && bus.CSR_WR_EN));
    endfunction

    // Advance model and DUT by one rising edge using the driven inputs
    task automatic tick();
        logic [32:0] r;
        logic [31:0] nv, mier_n, mtvec_n, scr_n, mepc_n, mcause_n;
        logic [63:0] cyc_n, ret_n;
        bit          we, mie_n, mpie_n, sw_n;
        r  = mread(bus.CSR_ADDR);
        we = bus.CSR_OP != 0 && bus.CSR_WR_EN && !mill();
        case (bus.CSR_OP)
            2'b01:   nv = bus.CSR_WDATA;
            2'b10:   nv = r[31:0] | bus.CSR_WDATA;
            default: nv = r[31:0] & ~bus.CSR_WDATA;
        endcase
        mie_n = m_mie; mpie_n = m_mpie; sw_n = m_sw;
        mier_n = m_mier; mtvec_n = m_mtvec; scr_n = m_scratch;
        mepc_n = m_mepc; mcause_n = m_mcause;
        cyc_n = m_cyc + 1;
        ret_n = m_ret + 64'(INSTRET_INC);
        if (we) begin
            case (bus.CSR_ADDR)
                12'h300: begin mie_n = nv[3]; mpie_n = nv[7]; end
                12'h304: mier_n   = nv & 32'h0000_0888;
                12'h305: mtvec_n  = nv & 32'hFFFF_FFFD;
                12'h340: scr_n    = nv;
                12'h341: mepc_n   = nv & 32'hFFFF_FFFC;
                12'h342: mcause_n = nv & 32'h8000_000F;
                12'h344: sw_n     = nv[3];
                12'hB00: cyc_n = {cyc_n[63:32], nv};
                12'hB80: cyc_n = {nv, cyc_n[31:0]};
                12'hB02: ret_n = {ret_n[63:32], nv};
                12'hB82: ret_n = {nv, ret_n[31:0]};
                default: ;
            endcase
        end
        if (SET_EPC)   mepc_n   = PC & 32'hFFFF_FFFC;
        if (SET_CAUSE) mcause_n = {I_OR_E, 27'b0, CAUSE};
        if (MIE_CLEAR) begin
            mpie_n = m_mie; mie_n = 0;
        end else if (MIE_SET) begin
            mie_n = m_mpie; mpie_n = 1;
        end
        @(posedge CLK);
        m_mie = mie_n; m_mpie = mpie_n; m_sw = sw_n;
        m_mier = mier_n; m_mtvec = mtvec_n; m_scratch = scr_n;
        m_mepc = mepc_n; m_mcause = mcause_n;
        m_cyc = cyc_n; m_ret = ret_n;
        m_meip = E_IRQ; m_mtip = T_IRQ; m_msip = sw_n | S_IRQ;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [32:0] r;
        logic [31:0] base, ta;
        r = mread(bus.CSR_ADDR);
        chk({tag, ".rdata"}, bus.CSR_RDATA,
            (bus.CSR_OP != 0 && r[32]) ? r[31:0] : 32'h0);
        chk({tag, ".illegal"}, bus.CSR_ILLEGAL, mill());
        chk({tag, ".status"}, {MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP},
            {m_mie, m_mier[11], m_mier[7], m_mier[3], m_meip, m_mtip, m_msip});
        base = m_mtvec & 32'hFFFF_FFFC;
        ta   = (m_mtvec[0] && m_mcause[31]) ? base + 4 * m_mcause[3:0] : base;
        chk({tag, ".trap_addr"}, TRAP_ADDR, ta);
        chk({tag, ".mepc"}, MEPC_OUT, m_mepc);
    endtask

    task automatic drv(input logic [1:0] op, input logic [11:0] a,
                       input logic we, input logic [31:0] d);
        bus.CSR_OP = op; bus.CSR_ADDR = a;
        bus.CSR_WR_EN = we; bus.CSR_WDATA = d;
    endtask

    task automatic clr();
        PC = 0; I_OR_E = 0; SET_EPC = 0; SET_CAUSE = 0; CAUSE = 0;
        INSTRET_INC = 0; MIE_CLEAR = 0; MIE_SET = 0;
        E_IRQ = 0; T_IRQ = 0; S_IRQ = 0;
    endtask

    initial begin
        RESET = 1'b0;
        clr();
        drv(2'b00, 12'h0, 1'b0, 32'h0);
        mreset();
        repeat (2) @(posedge CLK);
        #1 drv(2'b10, 12'h300, 1'b0, 32'h0);
        #2;
        chk("rst.mstatus", bus.CSR_RDATA, 32'h0000_1800);
        chk("rst.status", {MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP}, 7'h0);
        chk("rst.mepc", MEPC_OUT, 32'h0);
        chk("rst.trap_addr", TRAP_ADDR, 32'h0000_2000);
        drv(2'b10, 12'h305, 1'b0, 32'h0);
        #1 chk("rst.mtvec", bus.CSR_RDATA, TB_MTVEC);
        @(posedge CLK);
        #1 RESET = 1'b1;
        drv(2'b10, 12'hB00, 1'b0, 32'h0);
        #2 chk("cyc.first", bus.CSR_RDATA, 32'h0);
        tick();
        #2 chk("cyc.second", bus.CSR_RDATA, 32'h1);

        tbl.push_back(mk(2'b01, 12'h340, 1, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'h340, 1, 32'h0000_00F0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(2'b11, 12'h340, 1, 32'hF000_0000, 32'hDEADBEFF, 0));
        tbl.push_back(mk(2'b10, 12'h340, 0, 32'h0, 32'h0EADBEFF, 0));
        tbl.push_back(mk(2'b10, 12'h300, 0, 32'h0, 32'h0000_1800, 0));
        tbl.push_back(mk(2'b01, 12'h301, 1, 32'hFFFF_FFFF, 32'h4000_0100, 0));
        tbl.push_back(mk(2'b10, 12'h301, 0, 32'h0, 32'h4000_0100, 0));
        tbl.push_back(mk(2'b01, 12'h304, 1, 32'hFFFF_FFFF, 32'h0, 0));
        tbl.push_back(mk(2'b11, 12'h304, 1, 32'h0000_0008, 32'h0000_0888, 0));
        tbl.push_back(mk(2'b10, 12'h304, 0, 32'h0, 32'h0000_0880, 0));
        tbl.push_back(mk(2'b01, 12'h305, 1, 32'hFFFF_FFFF, TB_MTVEC, 0));
        tbl.push_back(mk(2'b10, 12'h305, 0, 32'h0, 32'hFFFF_FFFD, 0));
        tbl.push_back(mk(2'b01, 12'h343, 1, 32'hFFFF_FFFF, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'h343, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'h341, 1, 32'h0000_5557, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'h341, 0, 32'h0, 32'h0000_5554, 0));
        tbl.push_back(mk(2'b01, 12'h342, 1, 32'hFFFF_FFFF, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'h342, 0, 32'h0, 32'h8000_000F, 0));
        tbl.push_back(mk(2'b01, 12'h7C0, 1, 32'h0000_DEAD, 32'h0, 1));
        tbl.push_back(mk(2'b00, 12'h340, 1, 32'h0, 32'h0, 0));
        tbl.push_back(mk(2'b10, 12'hF11, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(2'b01, 12'hF12, 1, 32'h5, 32'h0, 1));
        tbl.push_back(mk(2'b10, 12'h7C0, 0, 32'h0, 32'h0, 1));
        foreach (tbl[i]) begin
            drv(tbl[i].op, tbl[i].addr, tbl[i].we, tbl[i].wd);
            #2;
            chk($sformatf("vec%0d.rdata", i), bus.CSR_RDATA, tbl[i].rd);
            chk($sformatf("vec%0d.illegal", i), bus.CSR_ILLEGAL, tbl[i].ill);
            tick();
        end

        // Trap entry then mret
        drv(2'b01, 12'h300, 1'b1, 32'h8);
        tick();
        drv(2'b00, 12'h0, 1'b0, 32'h0);
        PC = 32'h0000_1236; SET_EPC = 1; SET_CAUSE = 1; MIE_CLEAR = 1;
        I_OR_E = 1; CAUSE = 4'hB;
        tick();
        clr();
        drv(2'b10, 12'h342, 1'b0, 32'h0);
        #2;
        chk("trap.mepc", MEPC_OUT, 32'h0000_1234);
        chk("trap.mcause", bus.CSR_RDATA, 32'h8000_000B);
        chk("trap.mie", MIE, 1'b0);
        drv(2'b10, 12'h300, 1'b0, 32'h0);
        #1 chk("trap.mstatus", bus.CSR_RDATA, 32'h0000_1880);
        drv(2'b00, 12'h0, 1'b0, 32'h0);
        MIE_SET = 1;
        tick();
        clr();
        drv(2'b10, 12'h300, 1'b0, 32'h0);
        #2;
        chk("mret.mie", MIE, 1'b1);
        chk("mret.mstatus", bus.CSR_RDATA, 32'h0000_1888);

        // Vectored trap target
        drv(2'b01, 12'h305, 1'b1, 32'h0000_0101);
        tick();
        drv(2'b01, 12'h342, 1'b1, 32'h8000_0007);
        tick();
        drv(2'b00, 12'h0, 1'b0, 32'h0);
        #2 chk("vec.irq7", TRAP_ADDR, 32'h0000_011C);
        drv(2'b01, 12'h342, 1'b1, 32'h0000_0002);
        tick();
        drv(2'b00, 12'h0, 1'b0, 32'h0);
        #2 chk("vec.exc2", TRAP_ADDR, 32'h0000_0100);

        // mstatus write loses to trap-entry stack push
        drv(2'b01, 12'h300, 1'b1, 32'h8);
        MIE_CLEAR = 1;
        tick();
        clr();
        drv(2'b10, 12'h300, 1'b0, 32'h0);
        #2;
        chk("prio.mstatus", bus.CSR_RDATA, 32'h0000_1880);
        chk("prio.mie", MIE, 1'b0);

        // Counter carry from lo to hi
        drv(2'b01, 12'hB80, 1'b1, 32'h0);
        tick();
        drv(2'b01, 12'hB00, 1'b1, 32'hFFFF_FFFF);
        tick();
        drv(2'b10, 12'hB00, 1'b0, 32'h0);
        #2 chk("cnt.lo_max", bus.CSR_RDATA, 32'hFFFF_FFFF);
        tick();
        #2 chk("cnt.lo_wrap", bus.CSR_RDATA, 32'h0);
        tick();
        drv(2'b10, 12'hB80, 1'b0, 32'h0);
        #2 chk("cnt.hi_carry", bus.CSR_RDATA, 32'h1);
        drv(2'b10, 12'hC80, 1'b0, 32'h0);
        #1 chk("cnt.hi_alias", bus.CSR_RDATA, 32'h1);
        tick();
        drv(2'b10, 12'hC00, 1'b0, 32'h0);
        #2 chk("cnt.lo_alias", bus.CSR_RDATA, 32'h2);

        // Writes to the read-only quadrant fault and are dropped
        drv(2'b01, 12'hC00, 1'b1, 32'h0001_2345);
        #1;
        chk("ro.illegal", bus.CSR_ILLEGAL, 1'b1);
        chk("ro.rdata", bus.CSR_RDATA, 32'h2);
        tick();
        drv(2'b10, 12'hB00, 1'b0, 32'h0);
        #2 chk("ro.unaffected", bus.CSR_RDATA, 32'h3);
        drv(2'b10, 12'h7C0, 1'b0, 32'h0);
        #1;
        chk("unimpl.illegal", bus.CSR_ILLEGAL, 1'b1);
        chk("unimpl.rdata", bus.CSR_RDATA, 32'h0);
        tick();

        for (int i = 0; i < 400; i++) begin
            int k;
            int s;
            k = $urandom_range(0, 21);
            drv(2'($urandom_range(0, 3)), alist[k],
                1'($urandom_range(0, 1)), $urandom());
            PC          = $urandom();
            I_OR_E      = 1'($urandom_range(0, 1));
            CAUSE       = 4'($urandom_range(0, 15));
            SET_EPC     = ($urandom_range(0, 7) == 0);
            SET_CAUSE   = ($urandom_range(0, 7) == 0);
            s           = $urandom_range(0, 7);
            MIE_CLEAR   = (s == 0);
            MIE_SET     = (s == 1);
            INSTRET_INC = 1'($urandom_range(0, 1));
            E_IRQ       = 1'($urandom_range(0, 1));
            T_IRQ       = 1'($urandom_range(0, 1));
            S_IRQ       = ($urandom_range(0, 3) == 0);
            #2 check_model($sformatf("rnd%0d", i));
            tick();
        end
        clr();

        // Asynchronous reset mid-run
        drv(2'b01, 12'hB02, 1'b1, 32'h5);
        tick();
        drv(2'b01, 12'h304, 1'b1, 32'h0000_0888);
        tick();
        drv(2'b01, 12'h305, 1'b1, 32'h1234_5671);
        tick();
        drv(2'b10, 12'hB02, 1'b0, 32'h0);
        #2;
        chk("pre.minstret", bus.CSR_RDATA, 32'h5);
        chk("pre.meie", MEIE, 1'b1);
        RESET = 1'b0;
        #1;
        chk("arst.minstret", bus.CSR_RDATA, 32'h0);
        chk("arst.status", {MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP}, 7'h0);
        chk("arst.mepc", MEPC_OUT, 32'h0);
        drv(2'b10, 12'h305, 1'b0, 32'h0);
        #1 chk("arst.mtvec", bus.CSR_RDATA, TB_MTVEC);
        drv(2'b10, 12'h304, 1'b0, 32'h0);
        #1 chk("arst.mie", bus.CSR_RDATA, 32'h0);
        mreset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        drv(2'b10, 12'hB00, 1'b0, 32'h0);
        tick();
        tick();
        #2 check_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_csr_file.md
Name: machine_csr_file

Overview:
- Machine-mode CSR storage and trap-state update block for the Steel core.
- Sits directly downstream of the M-mode control FSM. It consumes that FSM's trap and return strobes: SET_EPC, SET_CAUSE, CAUSE, I_OR_E, MIE_CLEAR, MIE_SET, INSTRET_INC.
- It feeds back the interrupt-enable and interrupt-pending bits that the FSM evaluates.
- It serves Zicsr read/modify/write accesses from pipeline stage 3, and supplies the trap target address and MEPC to the PC mux.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE and MODE fields).
- MISA_VALUE, 32'h4000_0100, read-only misa contents (RV32I).

Ports:
- CLK  in  1  core clock, all state updated on rising edge
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
- CSR_ADDR  in  12  CSR address of current stage-3 instruction
- CSR_OP  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- CSR_WR_EN  in  1  write permitted; upstream deasserts for RS/RC with rs1/zimm = 0
- CSR_WDATA  in  32  rs1 value or zero-extended zimm
- CSR_RDATA  out  32  old CSR value, combinational
- CSR_ILLEGAL  out  1  combinational access-fault flag to the control unit
- PC  in  32  PC of the instruction being trapped
- I_OR_E  in  1  1 = interrupt, 0 = exception
- SET_EPC  in  1  capture PC into mepc
- SET_CAUSE  in  1  capture {I_OR_E, CAUSE} into mcause
- CAUSE  in  4  trap cause code
- INSTRET_INC  in  1  increment minstret
- MIE_CLEAR  in  1  trap entry stack push
- MIE_SET  in  1  mret stack pop
- E_IRQ / T_IRQ / S_IRQ  in  1 each  raw interrupt lines
- MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP  out  1 each  status, enable and pending bits
- TRAP_ADDR  out  32  trap vector target
- MEPC_OUT  out  32  current mepc

Behaviour:
- Reset (RESET=0, asynchronous):
  - all registers 0, except mtvec = MTVEC_RESET.
  - outputs: MIE=MPIE=0, enables 0, pending 0, MEPC_OUT=0.
- Read path: CSR_RDATA is combinational from CSR_ADDR and shows the pre-write value. It is 0 when CSR_OP=00 or the address is unimplemented.
- Write value (applied on the next edge when CSR_OP≠00, CSR_WR_EN=1, CSR_ILLEGAL=0):
  - RW: new = WDATA
  - RS: new = old | WDATA
  - RC: new = old & ~WDATA
- Address map:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11; other bits read 0 and ignore writes.
  - 0x301 misa: read-only, returns MISA_VALUE.
  - 0x304 mie: MEIE bit11, MTIE bit7, MSIE bit3 writable; others 0.
  - 0x305 mtvec: BASE[31:2] writable, MODE bit0 writable, bit1 hardwired 0.
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: {I_OR_E, 27'b0, CAUSE}, writable.
  - 0x343 mtval: reads 0, writes ignored.
  - 0x344 mip: MSIP bit3 writable; MEIP bit11 and MTIP bit7 read-only.
  - 0xB00/0xB80 mcycle lo/hi and 0xB02/0xB82 minstret lo/hi: writable.
  - 0xC00/0xC80 and 0xC02/0xC82: read-only aliases of mcycle and minstret.
  - 0xF11–0xF14: read 0.
- CSR_ILLEGAL = 1 when CSR_OP≠00 and either:
  - the address is unimplemented, or
  - addr[11:10]=2'b11 and CSR_WR_EN=1.
  The write is then suppressed.
- Pending bits (1-cycle registered):
  - MEIP <= E_IRQ; MTIP <= T_IRQ.
  - MSIP <= software bit OR S_IRQ. The software bit is held until cleared by a CSR write.
- Trap entry: SET_EPC loads mepc <= {PC[31:2], 2'b00}. SET_CAUSE loads mcause. MIE_CLEAR performs MPIE <= MIE, MIE <= 0.
- mret: MIE_SET performs MIE <= MPIE, MPIE <= 1.
- Priority in the same cycle: trap/mret strobes beat CSR writes to mstatus, mepc and mcause. A CSR write to a counter half beats that cycle's increment of that half.
- mcycle: increments every cycle when not in reset.
- minstret: increments when INSTRET_INC=1.
- Both counters are 64-bit; FFFF_FFFF_FFFF_FFFF wraps to 0. Carry from lo to hi occurs on the same edge.
- TRAP_ADDR (combinational):
  - {BASE, 2'b00} when MODE=0, or when mcause interrupt bit=0;
  - otherwise {BASE, 2'b00} + 4×mcause[3:0].
- MEPC_OUT equals mepc.
- No stalls; zero-latency reads; write-to-read visibility is 1 cycle.

Test Plan:
- Reset then CSR_OP=01, CSR_ADDR=0x340, WDATA=0xDEADBEEF; next cycle CSR_OP=10 with WDATA=0x0000_00F0 -> RDATA reads 0xDEADBEEF, mscratch becomes 0xDEADBEFF; then RC with 0xF000_0000 -> 0x0EADBEFF.
- mstatus MIE=1, MPIE=0, PC=0x0000_1236, SET_EPC=SET_CAUSE=MIE_CLEAR=1, I_OR_E=1, CAUSE=0xB -> mepc=0x1234, mcause=0x8000_000B, MIE=0, MPIE=1; then MIE_SET -> MIE=1, MPIE=1.
- mtvec=0x0000_0101 (vectored), mcause=0x8000_0007 -> TRAP_ADDR=0x0000_011C; mcause=0x0000_0002 -> TRAP_ADDR=0x0000_0100.
- Write mcycle lo=0xFFFF_FFFF and hi=0 -> next edge lo=0, hi=1; simultaneous RW to mstatus with MIE_CLEAR -> MIE=0 and the write is ignored.
- CSR_OP=01 to 0xC00 -> CSR_ILLEGAL=1 and mcycle unaffected; read of 0x7C0 -> CSR_ILLEGAL=1, RDATA=0.
- Assert RESET=0 mid-run after minstret=5 and mie=0x888 -> all clear asynchronously; mtvec returns to MTVEC_RESET.
